// File: rtl/uart_tx_fifo_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_drain_pkg
// Purpose  : Shared UART definitions: FSM encoding, parity types, line level.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_fifo_drain_pkg;

    // Transmitter FSM encoding, 3-bit wide
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } tx_state_e;

    // Parity type selector values
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Level of an idle (marking) serial line
    localparam logic LINE_IDLE = 1'b1;

    // Bit-counter width; at least one bit even for single-bit frames
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_parity_calc.sv
`default_nettype none
// ============================================================================
// Module   : uart_parity_calc
// Purpose  : Combinational parity bit generator, shared by UART TX and RX.
// Revision : 1.0 - initial release
// ============================================================================
module uart_parity_calc
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_bit_o
);

    // Even parity makes the total count of ones even; odd inverts that
    always_comb begin
        par_bit_o = (par_typ_i == PAR_ODD) ? ~^data_i : ^data_i;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_drain
// Purpose  : Pops words from the async FIFO read port and serialises each as
//            a UART frame (start, data LSB first, optional parity, stop),
//            one bit per clock. Back-to-back frames have no idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  r_inc_o,
    input  logic                  par_en_i,
    input  logic                  par_typ_i,
    output logic                  tx_out_o,
    output logic                  busy_o
);

    localparam int unsigned     CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  tx_q;
    logic                  busy_q;

    logic                  w_pop_ready;
    logic                  w_par_bit;

    // Parity of the head word, captured at the pop edge
    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_i    (rd_data_i),
        .par_typ_i (par_typ_i),
        .par_bit_o (w_par_bit)
    );

    // Pop only between frames (idle) or in the last stop cycle, never when empty
    always_comb begin
        w_pop_ready = !fifo_empty_i && ((state_q == S_IDLE) || (state_q == S_STOP));
    end

    assign r_inc_o  = w_pop_ready && !rst_i;
    assign tx_out_o = tx_q;
    assign busy_o   = busy_q;

    // Frame sequencer: state, shift register, bit counter and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= LINE_IDLE;
            busy_q    <= 1'b0;
        end else if (w_pop_ready) begin
            // Load word and freeze the frame's parity configuration
            state_q   <= S_START;
            shift_q   <= rd_data_i;
            cnt_q     <= '0;
            par_en_q  <= par_en_i;
            par_bit_q <= w_par_bit;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q   <= LINE_IDLE;
                    busy_q <= 1'b0;
                end
                S_START: begin
                    // Output bit 0 in the first DATA cycle
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    cnt_q   <= '0;
                    state_q <= S_DATA;
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (par_en_q) begin
                            tx_q    <= par_bit_q;
                            state_q <= S_PARITY;
                        end else begin
                            tx_q    <= LINE_IDLE;
                            state_q <= S_STOP;
                        end
                    end else begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    tx_q    <= LINE_IDLE;
                    state_q <= S_STOP;
                end
                S_STOP: begin
                    // No word waiting: return to idle
                    tx_q    <= LINE_IDLE;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    tx_q    <= LINE_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo_drain
// Purpose  : Self-checking bench for uart_tx_fifo_drain: frame table, directed
//            multi-cycle sequences and randomized traffic against a queue-based
//            frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_drain;

    logic       clk;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] rd_data;
    logic       r_inc;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int n_tests;
    int n_fail;

    // Bench-side FIFO contents and the frame bits still to be sent
    logic [7:0] fifo_q[$];
    bit         cur_bits[$];
    bit         hold_empty;

    // Observed history for multi-cycle checks
    bit hist_tx[$];
    bit hist_rinc[$];
    bit hist_busy[$];

    typedef struct {
        logic [7:0]  word;
        logic        pe;
        logic        pt;
        int          len;
        logic [10:0] frame;   // bit i = line level in the i-th frame cycle
    } vec_t;

    vec_t vecs[7];

    uart_tx_fifo_drain #(
        .DATA_WIDTH (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fifo_empty_i (fifo_empty),
        .rd_data_i    (rd_data),
        .r_inc_o      (r_inc),
        .par_en_i     (par_en),
        .par_typ_i    (par_typ),
        .tx_out_o     (tx_out),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsum(input bit q[$]);
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        return s;
    endfunction

    // Complete frame as a list of line levels, built from the framing rules
    function automatic void build_frame(input logic [7:0] w, input logic pe, input logic pt);
        int ones = 0;
        cur_bits.delete();
        cur_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            cur_bits.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (pe) cur_bits.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
        cur_bits.push_back(1'b1);
    endfunction

    task automatic drive_inputs();
        fifo_empty = (fifo_q.size() == 0) || hold_empty;
        rd_data    = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
    endtask

    // One clock cycle: predict, compare at negedge, advance model at posedge
    task automatic step();
        logic exp_pop, exp_tx, exp_busy;
        if (rst) cur_bits.delete();
        exp_pop  = !rst && !fifo_empty && (cur_bits.size() <= 1);
        exp_tx   = (cur_bits.size() != 0) ? cur_bits[0] : 1'b1;
        exp_busy = (cur_bits.size() != 0);
        @(negedge clk);
        check("r_inc", 32'(r_inc), 32'(exp_pop));
        check("tx_out", 32'(tx_out), 32'(exp_tx));
        check("busy", 32'(busy), 32'(exp_busy));
        hist_tx.push_back(tx_out);
        hist_rinc.push_back(r_inc);
        hist_busy.push_back(busy);
        @(posedge clk);
        if (exp_pop) begin
            logic [7:0] w;
            w = fifo_q.pop_front();
            build_frame(w, par_en, par_typ);
        end else if (cur_bits.size() != 0) begin
            void'(cur_bits.pop_front());
        end
        #1;
        drive_inputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_hist();
        hist_tx.delete();
        hist_rinc.delete();
        hist_busy.delete();
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        hold_empty = 1'b0;
        rst        = 1'b1;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        drive_inputs();

        // Frames are {stop, [parity], data, start} read from bit 0 upward
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 10, 11'h34A};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 11, 11'h54A};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 11, 11'h40E};
        vecs[3] = '{8'h03, 1'b1, 1'b1, 11, 11'h606};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 11, 11'h5FE};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 11, 11'h600};
        vecs[6] = '{8'h3C, 1'b0, 1'b1, 10, 11'h278};

        @(posedge clk);
        #1;

        // Reset held, then 20 empty cycles: line idle, no pops
        run(3);
        rst = 1'b0;
        clear_hist();
        run(20);
        check("idle_rinc_count", 32'(qsum(hist_rinc)), 32'd0);
        check("idle_busy_count", 32'(qsum(hist_busy)), 32'd0);

        // Single-frame table
        foreach (vecs[v]) begin
            logic [10:0] got;
            par_en  = vecs[v].pe;
            par_typ = vecs[v].pt;
            fifo_q.push_back(vecs[v].word);
            drive_inputs();
            clear_hist();
            run(vecs[v].len + 3);
            got = '0;
            for (int i = 0; i < vecs[v].len; i++) got[i] = hist_tx[1 + i];
            check($sformatf("frame_%0d", v), 32'(got), 32'(vecs[v].frame));
            check($sformatf("frame_rinc_%0d", v), 32'(qsum(hist_rinc)), 32'd1);
            check($sformatf("frame_len_%0d", v), 32'(qsum(hist_busy)), 32'(vecs[v].len));
            check($sformatf("frame_idle_%0d", v), 32'(hist_tx[vecs[v].len + 1]), 32'd1);
        end

        // Three queued words: pops at cycles 0, 10, 20; 30 contiguous busy cycles
        par_en = 1'b0;
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        drive_inputs();
        clear_hist();
        run(33);
        check("b2b_rinc_count", 32'(qsum(hist_rinc)), 32'd3);
        check("b2b_rinc_pos", 32'({hist_rinc[0], hist_rinc[10], hist_rinc[20]}), 32'b111);
        check("b2b_busy_count", 32'(qsum(hist_busy)), 32'd30);
        check("b2b_busy_edges", 32'({hist_busy[0], hist_busy[1], hist_busy[30], hist_busy[31]}), 32'b0110);

        // Reset during data bit 4 of 0xFF with another word waiting
        fifo_q.push_back(8'hFF);
        drive_inputs();
        run(6);
        rst = 1'b1;
        fifo_q.push_back(8'h5A);
        drive_inputs();
        #1;
        check("rst_tx_same_cycle", 32'(tx_out), 32'd1);
        clear_hist();
        run(3);
        check("rst_no_rinc", 32'(qsum(hist_rinc)), 32'd0);
        rst = 1'b0;
        clear_hist();
        run(13);
        check("rst_release_pop", 32'(hist_rinc[0]), 32'd1);
        check("rst_release_len", 32'(qsum(hist_busy)), 32'd10);

        // Config toggled mid-frame: first frame keeps parity, second has none
        par_en  = 1'b1;
        par_typ = 1'b1;
        fifo_q.push_back(8'h03);
        fifo_q.push_back(8'h07);
        drive_inputs();
        clear_hist();
        run(4);
        par_en  = 1'b0;
        par_typ = 1'b0;
        run(20);
        check("cfg_busy_count", 32'(qsum(hist_busy)), 32'd21);
        check("cfg_parity_bit", 32'(hist_tx[10]), 32'd1);

        // Randomized traffic: pushes, empty-flag stalls, config churn, rare resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 6) fifo_q.push_back(8'($urandom));
            hold_empty = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) begin
                par_en  = 1'($urandom);
                par_typ = 1'($urandom);
            end
            rst = ($urandom_range(0, 149) == 0);
            drive_inputs();
            step();
        end
        rst        = 1'b0;
        hold_empty = 1'b0;
        drive_inputs();
        run(80);
        check("drain_empty", 32'(fifo_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
